// File: rtl/bus_codes_pkg.sv
// bus_codes_pkg: shared main-bus code constants and transfer sequencer state encoding.
package bus_codes_pkg;
  localparam logic [3:0] BUS_ALU = 4'd1;
  localparam logic [3:0] BUS_DR  = 4'd2;
  localparam logic [3:0] BUS_R1  = 4'd3;
  localparam logic [3:0] BUS_R2  = 4'd4;
  localparam logic [3:0] BUS_R3  = 4'd5;
  localparam logic [3:0] BUS_R4  = 4'd6;
  localparam logic [3:0] BUS_R5  = 4'd7;
  localparam logic [3:0] BUS_R6  = 4'd8;
  localparam logic [3:0] BUS_R7  = 4'd9;
  localparam logic [3:0] BUS_R8  = 4'd10;
  localparam logic [3:0] BUS_R9  = 4'd11;
  localparam logic [3:0] BUS_R10 = 4'd12;
  localparam logic [3:0] BUS_DM  = 4'd13;
  localparam logic [3:0] BUS_IM  = 4'd14;
  localparam logic [3:0] BUS_ID  = 4'd15;
  typedef enum logic [1:0] {ST_IDLE, ST_SELECT, ST_LATCH, ST_WRITE} xfer_state_e;
  function automatic logic [15:0] code_onehot(input logic [3:0] c);
    return 16'(1) << c;
  endfunction
endpackage

// File: rtl/xfer_cmd_fifo.sv
// xfer_cmd_fifo: DEPTH-entry synchronous command FIFO with full/empty/occupancy.
module xfer_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [W-1:0]           data_i,
  output logic [W-1:0]           data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_q + AW'(push_i);
      rp_q  <= rp_q + AW'(pop_i);
      cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wp_q] <= data_i;
  end
  assign data_o  = mem_q[rp_q];
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign level_o = cnt_q;
endmodule

// File: rtl/bus_xfer_ctrl.sv
// bus_xfer_ctrl: queues register-to-register transfers and sequences the main-bus mux
// select, enable and destination write strobe with glitch-free select timing.
module bus_xfer_ctrl
  import bus_codes_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter int          WAIT_CYC = 1,
  parameter logic [15:0] DST_MASK = 16'h3FFC
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [3:0]               cmd_src,
  input  logic [3:0]               cmd_dst,
  output logic [3:0]               bus_select,
  output logic                     bus_enable,
  output logic [15:0]              wr_en,
  output logic                     done,
  output logic                     err,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int CW = $clog2(WAIT_CYC + 1);
  xfer_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    dst_q, dst_d, sel_q, sel_d;
  logic          en_q, en_d, done_q, done_d, err_q, err_d, busy_q, busy_d;
  logic [15:0]   wr_q, wr_d;
  logic          push, pop, full, empty, head_ok;
  logic [7:0]    head;
  logic [LW-1:0] level_n;
  xfer_cmd_fifo #(.DEPTH(DEPTH), .W(8)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  ({cmd_src, cmd_dst}),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign head_ok   = DST_MASK[head[3:0]];
  // Pops happen only from IDLE or at the end of WRITE, so select never moves mid-transfer.
  always_comb begin
    pop     = (state_q == ST_IDLE || state_q == ST_WRITE) && !empty;
    state_d = state_q;
    cnt_d   = cnt_q;
    dst_d   = dst_q;
    sel_d   = sel_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE, ST_WRITE: begin
        state_d = ST_IDLE;
        if (pop && head_ok) begin
          state_d = ST_SELECT;
          sel_d   = head[7:4];
          dst_d   = head[3:0];
          cnt_d   = CW'(WAIT_CYC);
        end else if (pop) begin
          err_d = 1'b1;
        end
      end
      ST_SELECT: begin
        cnt_d   = cnt_q - CW'(1);
        state_d = cnt_q == CW'(1) ? ST_LATCH : ST_SELECT;
      end
      ST_LATCH: state_d = ST_WRITE;
      default:  state_d = ST_IDLE;
    endcase
    en_d    = state_d == ST_LATCH;
    done_d  = state_d == ST_WRITE;
    wr_d    = done_d ? code_onehot(dst_d) : 16'h0;
    level_n = level + LW'(push) - LW'(pop);
    busy_d  = state_d != ST_IDLE || level_n != '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dst_q   <= '0;
      sel_q   <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      wr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dst_q   <= dst_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      wr_q    <= wr_d;
    end
  end
  assign bus_select = sel_q;
  assign bus_enable = en_q;
  assign wr_en      = wr_q;
  assign done       = done_q;
  assign err        = err_q;
  assign busy       = busy_q;
endmodule
